trace_readout: RTL and testbench
================================

TRACE_READOUT -- requirements
Module: trace_readout

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter BUFFER_LENGTH, default 256, meaning circular capture depth in samples; must be a power of 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tdata, input, AXIS_TDATA_WIDTH bits: signed input sample.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: sample qualifier; there is no s_axis_tready, so every valid sample is accepted.
REQ-007 SHALL have port arm, input, 1 bit: single-cycle capture request.
REQ-008 SHALL have port trigger, input, 1 bit: event marker, qualified by s_axis_tvalid.
REQ-009 SHALL have port pre_samples, input, 8 bits: number of samples captured before the trigger sample.
REQ-010 SHALL have port post_samples, input, 8 bits: number of samples captured after the trigger sample.
REQ-011 SHALL have port m_axis_tdata, output, AXIS_TDATA_WIDTH bits: readout sample.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit; port m_axis_tready, input, 1 bit; port m_axis_tlast, output, 1 bit.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port cfg_err, output, 1 bit: sticky flag for a rejected arm.

Function
REQ-015 SHALL implement the states IDLE, FILL, ARMED, POST and READOUT.
REQ-016 SHALL write each valid sample to mem[wr_ptr] and increment wr_ptr modulo BUFFER_LENGTH in FILL, ARMED and POST; no writes in IDLE or READOUT, so the buffer is frozen during readout.
REQ-017 SHALL, in IDLE, latch pre_samples/post_samples on arm and enter FILL, provided pre+post <= BUFFER_LENGTH-1.
REQ-018 SHALL, when pre+post > BUFFER_LENGTH-1 at arm, stay in IDLE and set cfg_err; cfg_err clears on the next accepted arm or on rst.
REQ-019 SHALL ignore arm outside IDLE.
REQ-020 SHALL move FILL -> ARMED once pre valid samples have been written since arm; with pre=0, at the first edge after entering FILL.
REQ-021 SHALL ignore trigger in IDLE, FILL, POST and READOUT.
REQ-022 SHALL, in ARMED, treat the sample written in a cycle where trigger && s_axis_tvalid is high as the trigger sample; record its address trig_addr and go to POST.
REQ-023 SHALL move POST -> READOUT after post further valid samples are written; with post=0, go straight from ARMED to READOUT.
REQ-024 SHALL, in READOUT, emit exactly pre+post+1 beats, oldest first, starting at address (trig_addr - pre) mod BUFFER_LENGTH, with addresses wrapping past BUFFER_LENGTH-1 to 0.
REQ-025 SHALL assert m_axis_tlast only on the final beat.
REQ-026 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid && !m_axis_tready.
REQ-027 SHALL complete a beat only on m_axis_tvalid && m_axis_tready; m_axis_tvalid SHALL NOT drop until that happens.
REQ-028 SHALL assert the first m_axis_tvalid no more than 3 cycles after entering READOUT, using synchronous memory reads with registered output.
REQ-029 SHALL sustain one beat per cycle while m_axis_tready is held high.
REQ-030 SHALL return to IDLE in the cycle after the tlast handshake; busy falls with the return to IDLE.
REQ-031 SHALL keep m_axis_tvalid low outside READOUT.
REQ-032 SHALL leave the output sample bits unmodified: no sign change and no width change.

Reset
REQ-033 SHALL, on rst, force state IDLE, wr_ptr=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0 and cfg_err=0; memory contents are undefined.
REQ-034 SHALL, on rst in any state including mid-readout, abort at once; no further beats are emitted.
REQ-035 SHALL give rst priority over arm, trigger and handshake inputs in the same cycle.

Verification
REQ-036 SHALL cover the basic capture: ramp 0,1,2,... continuous; arm with pre=4, post=3; trigger on sample 20 -> beats 16..23 (8 beats), tlast on 23, busy low afterwards.
REQ-037 SHALL cover wrap-around: BUFFER_LENGTH=256, trigger sample written at address 2, pre=5 -> first beat read from address 253, and the address sequence wraps 255 -> 0 correctly.
REQ-038 SHALL cover backpressure: m_axis_tready toggled randomly -> tdata/tlast stable while stalled, no lost or duplicated beats, order intact.
REQ-039 SHALL cover the configuration boundary: pre=200, post=56 -> cfg_err=1, stays IDLE; pre=200, post=55 -> accepted, 256 beats emitted.
REQ-040 SHALL cover ignored trigger and zero windows: trigger during FILL ignored; pre=0, post=0 -> exactly one beat equal to the trigger sample, with tlast=1.
REQ-041 SHALL cover reset mid-readout: rst after 3 beats of 8 -> tvalid=0 in the next cycle, IDLE, and no further beats.

Source files
------------

// File: rtl/trace_readout.sv
// Purpose : circular trace capture around a trigger sample, then an AXI-Stream readout of the window.
// Latency : first readout beat is valid 2 cycles after entering READOUT; then 1 beat/cycle.
// Backpr. : no input backpressure (every valid sample is accepted); the readout stalls losslessly on m_axis_tready.
//
// Ports:
//   clk, rst                       single clock, synchronous active-high reset
//   s_axis_tdata/tvalid            sample stream in (no tready)
//   arm, trigger                   capture request (IDLE only), event marker qualified by s_axis_tvalid
//   pre_samples, post_samples      window around the trigger sample, latched on an accepted arm
//   m_axis_tdata/tvalid/tready/tlast  readout stream, oldest sample first
//   busy, cfg_err                  not-IDLE indicator, sticky rejected-arm flag
module trace_readout #(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int BUFFER_LENGTH    = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        arm,
    input  logic                        trigger,
    input  logic [7:0]                  pre_samples,
    input  logic [7:0]                  post_samples,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic                        busy,
    output logic                        cfg_err
);

    localparam int AW = $clog2(BUFFER_LENGTH);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        READOUT
    } state_t;

    state_t state, state_nxt;

    logic [AXIS_TDATA_WIDTH-1:0] mem [BUFFER_LENGTH];

    logic [AW-1:0]               wr_ptr;
    logic [7:0]                  pre_q;
    logic [7:0]                  post_q;
    logic [8:0]                  fill_cnt;
    logic [8:0]                  post_cnt;
    logic [8:0]                  cfg_sum;

    // readout pipeline: memory output register (rd_*) feeding the output register (m_axis_*)
    logic [AW-1:0]               rd_addr;
    logic [8:0]                  issue_cnt;
    logic [AXIS_TDATA_WIDTH-1:0] rd_q;
    logic                        rd_vld;
    logic                        rd_last;

    logic                        wr_en;
    logic                        arm_ok;
    logic                        arm_bad;
    logic                        trig_hit;
    logic                        out_ld;
    logic                        s1_take;
    logic                        rd_en;

    assign cfg_sum = {1'b0, pre_samples} + {1'b0, post_samples};
    assign busy    = (state != IDLE);

    // Output register can load whenever it is empty or its beat is leaving this cycle.
    assign out_ld  = !m_axis_tvalid || m_axis_tready;
    assign s1_take = rd_vld && out_ld;
    // Only read when the memory output register is free or being drained, so a stall
    // simply holds rd_q and no read data is ever dropped.
    assign rd_en   = (state == READOUT) && (issue_cnt != 9'd0) && (!rd_vld || s1_take);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        arm_ok    = 1'b0;
        arm_bad   = 1'b0;
        trig_hit  = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    if (int'(cfg_sum) > BUFFER_LENGTH - 1) begin
                        arm_bad = 1'b1;
                    end else begin
                        arm_ok    = 1'b1;
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                wr_en = s_axis_tvalid;
                // counts the write happening this cycle, so pre=0 leaves on the first edge
                if ((fill_cnt + 9'(s_axis_tvalid)) >= {1'b0, pre_q}) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                wr_en = s_axis_tvalid;
                if (s_axis_tvalid && trigger) begin
                    trig_hit  = 1'b1;
                    state_nxt = (post_q == 8'd0) ? READOUT : POST;
                end
            end
            POST: begin
                wr_en = s_axis_tvalid;
                if (s_axis_tvalid && ((post_cnt + 9'd1) == {1'b0, post_q})) begin
                    state_nxt = READOUT;
                end
            end
            READOUT: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            pre_q         <= '0;
            post_q        <= '0;
            fill_cnt      <= '0;
            post_cnt      <= '0;
            cfg_err       <= 1'b0;
            rd_addr       <= '0;
            issue_cnt     <= '0;
            rd_vld        <= 1'b0;
            rd_last       <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else begin
            if (arm_ok) begin
                pre_q    <= pre_samples;
                post_q   <= post_samples;
                fill_cnt <= '0;
                cfg_err  <= 1'b0;
            end
            if (arm_bad) begin
                cfg_err <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (state == FILL && s_axis_tvalid) begin
                fill_cnt <= fill_cnt + 9'd1;
            end
            // The trigger sample lands at wr_ptr this cycle; the window starts pre below it.
            if (trig_hit) begin
                rd_addr   <= wr_ptr - AW'(pre_q);
                issue_cnt <= {1'b0, pre_q} + {1'b0, post_q} + 9'd1;
                post_cnt  <= '0;
            end
            if (state == POST && s_axis_tvalid) begin
                post_cnt <= post_cnt + 9'd1;
            end
            if (rd_en) begin
                rd_addr   <= rd_addr + AW'(1);
                issue_cnt <= issue_cnt - 9'd1;
                rd_last   <= (issue_cnt == 9'd1);
            end
            if (rd_en) begin
                rd_vld <= 1'b1;
            end else if (s1_take) begin
                rd_vld <= 1'b0;
            end
            if (out_ld) begin
                m_axis_tvalid <= rd_vld;
                m_axis_tlast  <= rd_vld && rd_last;
                if (rd_vld) begin
                    m_axis_tdata <= rd_q;
                end
            end
        end
    end

    // Sample memory has no reset so it maps onto block RAM; contents after rst are don't-care.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_trace_readout.sv
module tb_trace_readout;

    logic        clk;
    logic        rst;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        arm;
    logic        trigger;
    logic [7:0]  pre_samples;
    logic [7:0]  post_samples;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        busy;
    logic        cfg_err;

    trace_readout #(
        .AXIS_TDATA_WIDTH(16),
        .BUFFER_LENGTH   (256)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .arm          (arm),
        .trigger      (trigger),
        .pre_samples  (pre_samples),
        .post_samples (post_samples),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] samp        = 16'd0;
    logic [15:0] trig_at     = 16'hFFFF;
    logic [15:0] trig_early  = 16'hFFFF;
    bit          trig_early_en = 1'b0;
    bit          rnd_rdy     = 1'b0;
    bit          arm_req     = 1'b0;
    bit          rst_req     = 1'b0;
    bit          stalled     = 1'b0;
    logic [15:0] held_dat;
    logic        held_last;
    logic [15:0] got_q [$];
    bit          last_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, record the handshake that the
    // coming rising edge will complete, then return 1 time unit after that edge.
    task automatic cyc();
        @(negedge clk);
        rst     = rst_req;
        rst_req = 1'b0;
        arm     = arm_req;
        arm_req = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = samp;
        trigger = (samp == trig_at) || (trig_early_en && samp == trig_early);
        m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stalled && !rst) begin
            chk("stall_vld", m_axis_tvalid, 1);
            chk("stall_dat", m_axis_tdata, held_dat);
            chk("stall_last", m_axis_tlast, held_last);
        end
        stalled   = !rst && m_axis_tvalid && !m_axis_tready;
        held_dat  = m_axis_tdata;
        held_last = m_axis_tlast;
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(m_axis_tdata);
            last_q.push_back(m_axis_tlast);
        end
        samp = samp + 16'd1;
        @(posedge clk);
        #1;
    endtask

    // Arm a window, trigger toff samples after the earliest legal trigger, collect the
    // readout and compare it against the continuous ramp (trigger - pre onwards).
    task automatic capture(input logic [7:0] pre, input logic [7:0] post, input int toff,
                           input bit early, input int abort_at);
        int          exp_n;
        logic [15:0] first;
        bit          done;
        pre_samples  = pre;
        post_samples = post;
        got_q.delete();
        last_q.delete();
        trig_at       = samp + 16'd1 + 16'(pre) + 16'(toff);
        trig_early    = samp + 16'd2;
        trig_early_en = early;
        arm_req = 1'b1;
        cyc();
        chk("busy_after_arm", busy, 1);
        chk("cfg_err_after_arm", cfg_err, 0);
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            cyc();
            if (!busy) done = 1'b1;
            if (abort_at > 0 && got_q.size() == abort_at) done = 1'b1;
        end
        chk("finish_in_budget", done, 1);
        trig_early_en = 1'b0;
        first = trig_at - 16'(pre);
        if (abort_at > 0) begin
            rst_req = 1'b1;
            cyc();
            chk("rst_tvalid", m_axis_tvalid, 0);
            chk("rst_tlast", m_axis_tlast, 0);
            chk("rst_busy", busy, 0);
            repeat (20) cyc();
            exp_n = abort_at;
        end else begin
            exp_n = int'(pre) + int'(post) + 1;
        end
        chk("beat_count", got_q.size(), exp_n);
        chk("busy_end", busy, 0);
        chk("tvalid_end", m_axis_tvalid, 0);
        for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
            chk("beat_dat", got_q[i], first + 16'(i));
            chk("beat_last", last_q[i], (abort_at == 0 && i == exp_n - 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; arm = 1'b0; trigger = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        pre_samples = '0; post_samples = '0; m_axis_tready = 1'b1;

        // reset state
        rst_req = 1'b1;
        cyc();
        chk("reset_tvalid", m_axis_tvalid, 0);
        chk("reset_tlast", m_axis_tlast, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cfg_err", cfg_err, 0);

        // basic: arm on sample 5, pre=4 post=3, trigger on 20 (early trigger on 7 in FILL)
        while (samp != 16'd5) cyc();
        capture(8'd4, 8'd3, 10, 1'b1, 0);
        if (got_q.size() == 8) begin
            chk("basic_first", got_q[0], 16);
            chk("basic_last_dat", got_q[7], 23);
        end

        // wrap: from reset the trigger sample lands at address 2, window starts at 253
        rst_req = 1'b1;
        cyc();
        capture(8'd5, 8'd3, 253, 1'b0, 0);

        // backpressure with random tready
        rnd_rdy = 1'b1;
        capture(8'd6, 8'd9, 3, 1'b0, 0);
        rnd_rdy = 1'b0;

        // configuration boundary
        pre_samples  = 8'd200;
        post_samples = 8'd56;
        arm_req = 1'b1;
        cyc();
        chk("cfg_reject_err", cfg_err, 1);
        chk("cfg_reject_busy", busy, 0);
        repeat (3) cyc();
        chk("cfg_reject_idle", busy, 0);
        chk("cfg_err_sticky", cfg_err, 1);
        rst_req = 1'b1;
        cyc();
        chk("cfg_err_rst_clear", cfg_err, 0);
        arm_req = 1'b1;
        cyc();
        chk("cfg_reject_again", cfg_err, 1);
        capture(8'd200, 8'd55, 5, 1'b1, 0);

        // zero window: single beat equal to the trigger sample, tlast set
        capture(8'd0, 8'd0, 4, 1'b0, 0);

        // reset mid-readout after 3 of 8 beats
        capture(8'd4, 8'd3, 2, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
